// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers.
// Byte type, state count, InvSubBytes FSM enum, field mul/inverse.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_sb_state_t;

  // Multiply in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic aes_byte_t gf_mul(
    input aes_byte_t a,
    input aes_byte_t b
  );
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0.
  function automatic aes_byte_t gf_inv(
    input aes_byte_t a
  );
    aes_byte_t r;
    logic [7:0] e;
    e = 8'hfe;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/Inverse_S_box.sv
// AES inverse S-box: inverse affine map, then field inverse.
// Ports: din (byte in), dout (InvSBox(din)).
module Inverse_S_box
  import aes_pkg::*;
(
  input  aes_byte_t din,
  output aes_byte_t dout
);

  aes_byte_t aff;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign aff = {din[6:0], din[7]}
             ^ {din[4:0], din[7:5]}
             ^ {din[1:0], din[7:2]}
             ^ 8'h05;

  assign dout = gf_inv(aff);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Multi-cycle InvSubBytes sharing LANES inverse S-boxes.
// Ports: clk, rst, in_valid/in_ready/in_state, out_valid/out_ready/out_state, busy.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCHUNK = AES_NUM_BYTES / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW = $clog2(LANES);

  if (AES_NUM_BYTES % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide 16");
  end

  inv_sb_state_t state;
  logic [CW-1:0] cnt;

  // Element 15 holds byte 0 (the MSB byte).
  aes_byte_t [AES_NUM_BYTES-1:0] src_reg;
  aes_byte_t [AES_NUM_BYTES-1:0] res_reg;

  logic [3:0] base;
  logic [3:0] pos    [LANES];
  aes_byte_t  sb_in  [LANES];
  aes_byte_t  sb_out [LANES];

  assign base = 4'(cnt) << LW;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign pos[j]   = 4'(AES_NUM_BYTES - 1) - (base + 4'(j));
    assign sb_in[j] = src_reg[pos[j]];

    Inverse_S_box u_sbox (
      .din  (sb_in[j]),
      .dout (sb_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      src_reg <= '0;
      res_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            src_reg <= in_state;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            res_reg[pos[j]] <= sb_out[j];
          end
          if (cnt == CW'(NCHUNK - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = res_reg;

endmodule
